// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen
//   Turns the single-ended PWM waveform into a complementary high-side /
//   low-side gate-drive pair. A programmable dead interval always separates
//   the two drives.
//
// Parameters
//   DT_W         width of dead_time and of the dead-time down-counter
//   SYNC_STAGES  flops in the pwm_in / fault synchronizers (2 or more)
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   en           1 = drive outputs, 0 = both outputs low
//   pwm_in       PWM waveform from the PWM core
//   dead_time    dead interval in clk cycles (0 behaves as 1)
//   out_hi       high-side drive (registered)
//   out_lo       low-side drive (registered)
//   busy_dead    1 while in a dead interval (registered)
//   fault        fault request, synchronized like pwm_in  (PWM_DT_FAULT_EN only)
//   fault_clr    fault clear request                      (PWM_DT_FAULT_EN only)
//   fault_active 1 while the fault latch holds            (PWM_DT_FAULT_EN only)
//
// Build option
//   `define PWM_DT_FAULT_EN to add the fault ports and the latched FAULT state.
//   Without it the block has no fault logic at all.

module pwm_deadtime_gen #(
  parameter int unsigned DT_W        = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_time,
`ifdef PWM_DT_FAULT_EN
  input  logic            fault,
  input  logic            fault_clr,
  output logic            fault_active,
`endif
  output logic            out_hi,
  output logic            out_lo,
  output logic            busy_dead
);

  // State encoding
  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_DEAD_R = 3'd1;  // dead interval before high side
  localparam logic [2:0] ST_HIGH   = 3'd2;
  localparam logic [2:0] ST_DEAD_F = 3'd3;  // dead interval before low side
  localparam logic [2:0] ST_LOW    = 3'd4;
`ifdef PWM_DT_FAULT_EN
  localparam logic [2:0] ST_FAULT  = 3'd5;
`endif

  logic [SYNC_STAGES-1:0] pwm_sync_q;
  logic                   pwm_s;

  logic [2:0]             state_q;
  logic [2:0]             state_d;
  logic [DT_W-1:0]        cnt_q;
  logic [DT_W-1:0]        cnt_d;
  logic [DT_W-1:0]        dt_load_c;
  logic                   dead_now_c;
  logic                   dead_next_c;

  // pwm_in synchronizer; the FSM only ever looks at the last stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_sync_q <= '0;
    end else begin
      pwm_sync_q <= {pwm_sync_q[SYNC_STAGES-2:0], pwm_in};
    end
  end

  assign pwm_s = pwm_sync_q[SYNC_STAGES-1];

`ifdef PWM_DT_FAULT_EN
  logic [SYNC_STAGES-1:0] fault_sync_q;
  logic                   fault_s;

  // fault synchronizer, same depth as the pwm_in path
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sync_q <= '0;
    end else begin
      fault_sync_q <= {fault_sync_q[SYNC_STAGES-2:0], fault};
    end
  end

  assign fault_s = fault_sync_q[SYNC_STAGES-1];
`endif

  // Counter reload value: D-1 where D = max(dead_time, 1)
  assign dt_load_c = (dead_time == '0) ? '0 : dead_time - DT_W'(1);

  assign dead_now_c  = (state_q == ST_DEAD_R) || (state_q == ST_DEAD_F);
  assign dead_next_c = (state_d == ST_DEAD_R) || (state_d == ST_DEAD_F);

  // Next-state logic. Priority: fault > en=0 > normal sequencing.
  always_comb begin
    state_d = state_q;
`ifdef PWM_DT_FAULT_EN
    if (fault_s) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      // latched until cleared while the synced fault is low
      if (fault_clr) begin
        state_d = ST_OFF;
      end
    end else
`endif
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:    state_d = pwm_s ? ST_DEAD_R : ST_DEAD_F;
        ST_LOW:    if (pwm_s) state_d = ST_DEAD_R;
        ST_HIGH:   if (!pwm_s) state_d = ST_DEAD_F;
        // An input reversal mid-interval returns to the side that the
        // reversed input asks for; that side is the one just released,
        // so no overlap is possible.
        ST_DEAD_R: begin
          if (!pwm_s) begin
            state_d = ST_LOW;
          end else if (cnt_q == '0) begin
            state_d = ST_HIGH;
          end
        end
        ST_DEAD_F: begin
          if (pwm_s) begin
            state_d = ST_HIGH;
          end else if (cnt_q == '0) begin
            state_d = ST_LOW;
          end
        end
        default:   state_d = ST_OFF;
      endcase
    end
  end

  // Dead-time counter: dead_time is captured only on entry to a dead state,
  // then counts down to zero and holds there.
  always_comb begin
    cnt_d = cnt_q;
    if (dead_next_c && (state_d != state_q)) begin
      cnt_d = dt_load_c;
    end else if (dead_now_c && (cnt_q != '0)) begin
      cnt_d = cnt_q - DT_W'(1);
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output registers, decoded from next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (rst) begin
      out_hi    <= 1'b0;
      out_lo    <= 1'b0;
      busy_dead <= 1'b0;
    end else begin
      out_hi    <= (state_d == ST_HIGH);
      out_lo    <= (state_d == ST_LOW);
      busy_dead <= dead_next_c;
    end
  end

`ifdef PWM_DT_FAULT_EN
  // Fault indicator register
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_active <= 1'b0;
    end else begin
      fault_active <= (state_d == ST_FAULT);
    end
  end
`endif

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Testbench for pwm_deadtime_gen: directed table, PWM-core waveforms and
// randomized traffic checked against a behavioural model of the drive rules.

module tb_pwm_deadtime_gen;

  localparam int unsigned DT_W = 8;
  localparam int unsigned SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dead_time;
  logic            out_hi;
  logic            out_lo;
  logic            busy_dead;
`ifdef PWM_DT_FAULT_EN
  logic            fault;
  logic            fault_clr;
  logic            fault_active;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_deadtime_gen #(.DT_W(DT_W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pwm_in       (pwm_in),
    .dead_time    (dead_time),
`ifdef PWM_DT_FAULT_EN
    .fault        (fault),
    .fault_clr    (fault_clr),
    .fault_active (fault_active),
`endif
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .busy_dead    (busy_dead)
  );

  // ---------------- behavioural model ----------------
  // Modes: which side is driven, a pending dead interval toward a side,
  // or the fault latch. The synchronizer is a plain delay queue.
  localparam int M_OFF = 0, M_HI = 1, M_LO = 2, M_DEAD = 3, M_FAULT = 4;
  int   m_mode = M_OFF;
  int   m_target = M_HI;
  int   m_rem = 0;
  logic pin_q[$];
`ifdef PWM_DT_FAULT_EN
  logic flt_q[$];
`endif

  task automatic start_dead(input int tgt);
    m_mode   = M_DEAD;
    m_target = tgt;
    m_rem    = (dead_time == 0) ? 1 : int'(dead_time);
  endtask

  task automatic model_step();
    logic s;
    if (rst) begin
      m_mode = M_OFF;
      pin_q  = {};
      for (int i = 0; i < SYNC; i++) pin_q.push_back(1'b0);
`ifdef PWM_DT_FAULT_EN
      flt_q = {};
      for (int i = 0; i < SYNC; i++) flt_q.push_back(1'b0);
`endif
      return;
    end
    s = pin_q.pop_front();
    pin_q.push_back(pwm_in);
`ifdef PWM_DT_FAULT_EN
    begin
      logic fs;
      fs = flt_q.pop_front();
      flt_q.push_back(fault);
      if (fs) begin
        m_mode = M_FAULT;
        return;
      end
      if (m_mode == M_FAULT) begin
        if (fault_clr) m_mode = M_OFF;
        return;
      end
    end
`endif
    if (!en) begin
      m_mode = M_OFF;
      return;
    end
    case (m_mode)
      M_OFF: start_dead(s ? M_HI : M_LO);
      M_HI:  if (!s) start_dead(M_LO);
      M_LO:  if (s) start_dead(M_HI);
      M_DEAD: begin
        if (s != (m_target == M_HI)) m_mode = s ? M_HI : M_LO;
        else if (m_rem == 1)         m_mode = m_target;
        else                         m_rem--;
      end
      default: m_mode = M_OFF;
    endcase
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_hi"},   int'(out_hi),    int'(m_mode == M_HI));
    chk({tag, "_lo"},   int'(out_lo),    int'(m_mode == M_LO));
    chk({tag, "_busy"}, int'(busy_dead), int'(m_mode == M_DEAD));
`ifdef PWM_DT_FAULT_EN
    chk({tag, "_fault"}, int'(fault_active), int'(m_mode == M_FAULT));
`endif
  endtask

  // Drive one cycle of inputs, clock it, advance the model, sample after the edge
  task automatic step(input logic r, input logic e, input logic p, input logic [DT_W-1:0] d);
    rst = r; en = e; pwm_in = p; dead_time = d;
    @(posedge clk);
    model_step();
    #1;
    chk("no_overlap", int'(out_hi & out_lo), 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic            rst;
    logic            en;
    logic            pwm;
    logic [DT_W-1:0] dt;
    logic            hi;
    logic            lo;
    logic            busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic p, input int d,
                     input logic h, input logic l, input logic b);
    vec_t v;
    v.rst = r; v.en = e; v.pwm = p; v.dt = DT_W'(d);
    v.hi = h; v.lo = l; v.busy = b;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; dead_time = '0;
`ifdef PWM_DT_FAULT_EN
    fault = 1'b0; fault_clr = 1'b0;
`endif
    for (int i = 0; i < SYNC; i++) pin_q.push_back(1'b0);
`ifdef PWM_DT_FAULT_EN
    for (int i = 0; i < SYNC; i++) flt_q.push_back(1'b0);
`endif

    // Reset held 3 cycles with pwm_in=1, en=1: outputs stay off
    add(1,1,1,3, 0,0,0); add(1,1,1,3, 0,0,0); add(1,1,1,3, 0,0,0);
    // Release: synchronizer still holds its reset zeros for SYNC cycles
    add(0,1,1,3, 0,0,1); add(0,1,1,3, 0,0,1); add(0,1,1,3, 1,0,0);
    add(0,1,1,3, 1,0,0);
    // Falling input: high drops 3 cycles later, low after D=3 dead cycles
    add(0,1,0,3, 1,0,0); add(0,1,0,3, 1,0,0); add(0,1,0,3, 0,0,1);
    add(0,1,0,3, 0,0,1); add(0,1,0,3, 0,0,1); add(0,1,0,3, 0,1,0);
    add(0,1,0,3, 0,1,0);
    // 2-cycle high pulse shorter than D: high never asserts, low returns
    add(0,1,1,3, 0,1,0); add(0,1,1,3, 0,1,0); add(0,1,0,3, 0,0,1);
    add(0,1,0,3, 0,0,1); add(0,1,0,3, 0,1,0); add(0,1,0,3, 0,1,0);
    // dead_time=0 acts as a single dead cycle
    add(0,1,1,0, 0,1,0); add(0,1,1,0, 0,1,0); add(0,1,1,0, 0,0,1);
    add(0,1,1,0, 1,0,0);
    // en=0 forces off in one cycle, en=1 re-enters through a dead interval
    add(0,0,1,2, 0,0,0); add(0,1,1,2, 0,0,1); add(0,1,1,2, 0,0,1);
    add(0,1,1,2, 1,0,0);
    // dead_time changed mid-interval is ignored
    add(0,1,0,2, 1,0,0); add(0,1,0,2, 1,0,0); add(0,1,0,2, 0,0,1);
    add(0,1,0,7, 0,0,1); add(0,1,0,7, 0,1,0);

    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].pwm, tbl[i].dt);
      chk($sformatf("tbl%0d_hi", i),   int'(out_hi),    int'(tbl[i].hi));
      chk($sformatf("tbl%0d_lo", i),   int'(out_lo),    int'(tbl[i].lo));
      chk($sformatf("tbl%0d_busy", i), int'(busy_dead), int'(tbl[i].busy));
    end

    // PWM core waveform, duty 250 then 0, dead_time=3, two periods each
    step(1'b1, 1'b0, 1'b0, DT_W'(3));
    for (int duty = 250; duty >= 0; duty -= 250) begin
      for (int c = 0; c < 512; c++) begin
        step(1'b0, 1'b1, logic'((c % 256) < duty), DT_W'(3));
        chk_model($sformatf("pwm%0d", duty));
      end
    end

`ifdef PWM_DT_FAULT_EN
    // Fault mid-HIGH: latched off until cleared, then normal restart
    step(1'b1, 1'b0, 1'b0, DT_W'(2));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1, DT_W'(2));
    chk("flt_pre_hi", int'(out_hi), 1);
    fault = 1'b1;
    for (int i = 0; i < SYNC + 1; i++) step(1'b0, 1'b1, 1'b1, DT_W'(2));
    chk("flt_off_hi", int'(out_hi | out_lo), 0);
    chk("flt_active", int'(fault_active), 1);
    fault = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, DT_W'(2));
      chk_model("flt_hold");
    end
    fault = 1'b1; fault_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, DT_W'(2));
      chk_model("flt_both");
    end
    chk("flt_wins", int'(fault_active), 1);
    fault = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, DT_W'(2));
      chk_model("flt_clr");
    end
    fault_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b1, DT_W'(2));
      chk_model("flt_resume");
    end
    chk("flt_resume_hi", int'(out_hi), 1);
    chk("flt_cleared", int'(fault_active), 0);
`endif

    // Randomized traffic against the model
    begin
      logic            p = 1'b0;
      int              run = 1;
      logic [DT_W-1:0] d = DT_W'(2);
      for (int i = 0; i < 3000; i++) begin
        if (--run <= 0) begin
          p   = ~p;
          run = int'($urandom_range(1, 9));
        end
        if ($urandom_range(0, 29) == 0) d = DT_W'($urandom_range(0, 6));
`ifdef PWM_DT_FAULT_EN
        fault     = ($urandom_range(0, 99) == 0);
        fault_clr = ($urandom_range(0, 3) == 0);
`endif
        step(logic'($urandom_range(0, 249) == 0), logic'($urandom_range(0, 39) != 0), p, d);
        chk_model("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
